// File: rtl/udp_pkg.sv
// Shared definitions for the UDP payload scheduler: FSM state encodings,
// header/bank constants and length arithmetic.
`timescale 1ns/1ps
package udp_pkg;

   localparam int BANK_WORDS    = 256;
   localparam int BANK_AW       = $clog2(BANK_WORDS);
   localparam int UDP_HDR_BYTES = 8;
   localparam int IP_HDR_BYTES  = 20;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ECHO = 2'd1,
      W_MEAS = 2'd2
   } wr_state_t;

   typedef enum logic [1:0] {
      T_IDLE = 2'd0,
      T_REQ  = 2'd1,
      T_WAIT = 2'd2
   } tx_state_t;

   // UDP length of a measurement frame holding 'words' 32-bit payload words
   function automatic logic [15:0] meas_data_len(input logic [BANK_AW:0] words);
      meas_data_len = 16'({words, 2'b00}) + 16'(UDP_HDR_BYTES);
   endfunction

   function automatic logic [15:0] ip_total_len(input logic [15:0] udp_len);
      ip_total_len = udp_len + 16'(IP_HDR_BYTES);
   endfunction

endpackage

// File: rtl/payload_bank_ctrl.sv
// Full/length bookkeeping for the two ping-pong payload banks; a commit and a
// free on different banks in the same cycle both take effect.
`timescale 1ns/1ps
module payload_bank_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        commit_valid,
   input  logic        commit_bank,
   input  logic [15:0] commit_len,
   input  logic        free_valid,
   input  logic        free_bank,
   input  logic        rd_bank,
   output logic [1:0]  bank_full,
   output logic [15:0] rd_len
);

   logic [1:0]  full_r;
   logic [15:0] len_r [2];

   // bank occupancy and stored UDP length per bank
   always_ff @(posedge clk) begin
      if (reset) begin
         full_r   <= 2'b00;
         len_r[0] <= 16'd0;
         len_r[1] <= 16'd0;
      end else begin
         if (commit_valid) begin
            full_r[commit_bank] <= 1'b1;
            len_r[commit_bank]  <= commit_len;
         end
         if (free_valid) begin
            full_r[free_bank] <= 1'b0;
         end
      end
   end

   assign bank_full = full_r;
   assign rd_len    = len_r[rd_bank];

endmodule

// File: rtl/udp_payload_scheduler.sv
// Arbitrates echo and measurement payloads into two RAM banks and issues one
// UDP transmit request per completed bank.
`timescale 1ns/1ps
module udp_payload_scheduler
   import udp_pkg::*;
(
   input  logic        e_rxc,
   input  logic        reset,
   input  logic        rx_wr_valid,
   input  logic [8:0]  rx_wr_addr,
   input  logic [31:0] rx_wr_data,
   input  logic        rx_frame_done,
   input  logic [15:0] rx_data_length,
   input  logic        meas_valid,
   output logic        meas_ready,
   input  logic [31:0] meas_data,
   input  logic        meas_last,
   output logic        ram_wren,
   output logic [8:0]  ram_wraddr,
   output logic [31:0] ram_wrdata,
   output logic        tx_req,
   input  logic        tx_busy,
   input  logic        tx_done,
   output logic        tx_bank,
   output logic [15:0] tx_data_length,
   output logic [15:0] tx_total_length,
   output logic [15:0] frames_sent,
   output logic [7:0]  drop_cnt
);

   wr_state_t   wr_state_r;
   tx_state_t   tx_state_r;
   logic        fill_bank_r;
   logic        tx_ptr_r;
   logic [7:0]  wcnt_r;
   logic        ram_wren_r;
   logic [8:0]  ram_wraddr_r;
   logic [31:0] ram_wrdata_r;
   logic [7:0]  drop_cnt_r;
   logic        tx_req_r;
   logic        tx_bank_r;
   logic [15:0] tx_dlen_r;
   logic [15:0] tx_tlen_r;
   logic [15:0] frames_r;

   logic [1:0]  bank_full_s;
   logic [15:0] rd_len_s;
   logic        fill_free_s;
   logic        meas_ready_s;
   logic        echo_grant_s;
   logic        echo_wr_s;
   logic        echo_commit_s;
   logic        drop_s;
   logic        meas_acc_s;
   logic        meas_commit_s;
   logic        commit_valid_s;
   logic [15:0] commit_len_s;
   logic [8:0]  words_s;
   logic        free_valid_s;
   logic        unused_addr_msb_s;

   assign unused_addr_msb_s = rx_wr_addr[8];
   assign fill_free_s       = ~bank_full_s[fill_bank_r];
   assign words_s           = {1'b0, wcnt_r} + 9'd1;
   assign free_valid_s      = (tx_state_r == T_WAIT) && tx_done;

   // measurement handshake: open in W_MEAS, or in W_IDLE when echo is not claiming the port
   always_comb begin
      meas_ready_s = 1'b0;
      if (reset) begin
         meas_ready_s = 1'b0;
      end else if (wr_state_r == W_MEAS) begin
         meas_ready_s = 1'b1;
      end else if ((wr_state_r == W_IDLE) && fill_free_s && !rx_wr_valid) begin
         meas_ready_s = 1'b1;
      end else begin
         meas_ready_s = 1'b0;
      end
   end

   // write-port grant, commit and drop decode; an echo frame opens with a word
   always_comb begin
      echo_grant_s = 1'b0;
      case (wr_state_r)
         W_IDLE:  echo_grant_s = fill_free_s && rx_wr_valid;
         W_ECHO:  echo_grant_s = 1'b1;
         W_MEAS:  echo_grant_s = 1'b0;
         default: echo_grant_s = 1'b0;
      endcase
      echo_wr_s      = echo_grant_s && rx_wr_valid;
      echo_commit_s  = echo_grant_s && rx_frame_done;
      drop_s         = rx_frame_done && !echo_grant_s;
      meas_acc_s     = meas_valid && meas_ready_s;
      meas_commit_s  = meas_acc_s && (meas_last || (wcnt_r == 8'(BANK_WORDS - 1)));
      commit_valid_s = echo_commit_s || meas_commit_s;
      if (echo_commit_s) begin
         commit_len_s = rx_data_length;
      end else begin
         commit_len_s = meas_data_len(words_s);
      end
   end

   payload_bank_ctrl u_bank_ctrl (
      .clk          (e_rxc),
      .reset        (reset),
      .commit_valid (commit_valid_s),
      .commit_bank  (fill_bank_r),
      .commit_len   (commit_len_s),
      .free_valid   (free_valid_s),
      .free_bank    (tx_ptr_r),
      .rd_bank      (tx_ptr_r),
      .bank_full    (bank_full_s),
      .rd_len       (rd_len_s)
   );

   // write FSM with registered RAM write port and drop counter
   always_ff @(posedge e_rxc) begin
      if (reset) begin
         wr_state_r   <= W_IDLE;
         fill_bank_r  <= 1'b0;
         wcnt_r       <= 8'd0;
         ram_wren_r   <= 1'b0;
         ram_wraddr_r <= 9'd0;
         ram_wrdata_r <= 32'd0;
         drop_cnt_r   <= 8'd0;
      end else begin
         ram_wren_r <= 1'b0;
         if (echo_wr_s) begin
            ram_wren_r   <= 1'b1;
            ram_wraddr_r <= {fill_bank_r, rx_wr_addr[7:0]};
            ram_wrdata_r <= rx_wr_data;
         end else if (meas_acc_s) begin
            ram_wren_r   <= 1'b1;
            ram_wraddr_r <= {fill_bank_r, wcnt_r};
            ram_wrdata_r <= meas_data;
         end
         if (meas_commit_s) begin
            wcnt_r <= 8'd0;
         end else if (meas_acc_s) begin
            wcnt_r <= wcnt_r + 8'd1;
         end
         if (commit_valid_s) begin
            fill_bank_r <= ~fill_bank_r;
         end
         if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
         end
         case (wr_state_r)
            W_IDLE: begin
               if (echo_grant_s) begin
                  wr_state_r <= echo_commit_s ? W_IDLE : W_ECHO;
               end else if (meas_acc_s && !meas_commit_s) begin
                  wr_state_r <= W_MEAS;
               end
            end
            W_ECHO: if (echo_commit_s) wr_state_r <= W_IDLE;
            W_MEAS: if (meas_commit_s) wr_state_r <= W_IDLE;
            default: wr_state_r <= W_IDLE;
         endcase
      end
   end

   // TX FSM: lengths are latched on request so they hold until tx_done
   always_ff @(posedge e_rxc) begin
      if (reset) begin
         tx_state_r <= T_IDLE;
         tx_ptr_r   <= 1'b0;
         tx_req_r   <= 1'b0;
         tx_bank_r  <= 1'b0;
         tx_dlen_r  <= 16'd0;
         tx_tlen_r  <= 16'd0;
         frames_r   <= 16'd0;
      end else begin
         case (tx_state_r)
            T_IDLE: begin
               if (bank_full_s[tx_ptr_r]) begin
                  tx_req_r   <= 1'b1;
                  tx_bank_r  <= tx_ptr_r;
                  tx_dlen_r  <= rd_len_s;
                  tx_tlen_r  <= ip_total_len(rd_len_s);
                  tx_state_r <= T_REQ;
               end
            end
            T_REQ: begin
               if (tx_busy) begin
                  tx_req_r   <= 1'b0;
                  tx_state_r <= T_WAIT;
               end
            end
            T_WAIT: begin
               if (tx_done) begin
                  tx_ptr_r   <= ~tx_ptr_r;
                  tx_state_r <= T_IDLE;
                  if (frames_r != 16'hFFFF) begin
                     frames_r <= frames_r + 16'd1;
                  end
               end
            end
            default: begin
               tx_req_r   <= 1'b0;
               tx_state_r <= T_IDLE;
            end
         endcase
      end
   end

   assign meas_ready      = meas_ready_s;
   assign ram_wren        = ram_wren_r;
   assign ram_wraddr      = ram_wraddr_r;
   assign ram_wrdata      = ram_wrdata_r;
   assign tx_req          = tx_req_r;
   assign tx_bank         = tx_bank_r;
   assign tx_data_length  = tx_dlen_r;
   assign tx_total_length = tx_tlen_r;
   assign frames_sent     = frames_r;
   assign drop_cnt        = drop_cnt_r;

endmodule

// File: tb/tb_udp_payload_scheduler.sv
// Self-checking bench for udp_payload_scheduler: table of frames plus corner
// sequences, with a write scoreboard fed from the stimulus side.
`timescale 1ns/1ps
module tb_udp_payload_scheduler;

   logic        e_rxc = 1'b0;
   logic        reset;
   logic        rx_wr_valid;
   logic [8:0]  rx_wr_addr;
   logic [31:0] rx_wr_data;
   logic        rx_frame_done;
   logic [15:0] rx_data_length;
   logic        meas_valid;
   logic        meas_ready;
   logic [31:0] meas_data;
   logic        meas_last;
   logic        ram_wren;
   logic [8:0]  ram_wraddr;
   logic [31:0] ram_wrdata;
   logic        tx_req;
   logic        tx_busy;
   logic        tx_done;
   logic        tx_bank;
   logic [15:0] tx_data_length;
   logic [15:0] tx_total_length;
   logic [15:0] frames_sent;
   logic [7:0]  drop_cnt;

   udp_payload_scheduler dut (
      .e_rxc(e_rxc), .reset(reset),
      .rx_wr_valid(rx_wr_valid), .rx_wr_addr(rx_wr_addr), .rx_wr_data(rx_wr_data),
      .rx_frame_done(rx_frame_done), .rx_data_length(rx_data_length),
      .meas_valid(meas_valid), .meas_ready(meas_ready), .meas_data(meas_data),
      .meas_last(meas_last),
      .ram_wren(ram_wren), .ram_wraddr(ram_wraddr), .ram_wrdata(ram_wrdata),
      .tx_req(tx_req), .tx_busy(tx_busy), .tx_done(tx_done), .tx_bank(tx_bank),
      .tx_data_length(tx_data_length), .tx_total_length(tx_total_length),
      .frames_sent(frames_sent), .drop_cnt(drop_cnt)
   );

   always #4 e_rxc = ~e_rxc;

   int          nchecks = 0;
   int          nerrors = 0;
   logic [40:0] exp_q [$];
   logic        m_fill = 1'b0;
   int          m_wcnt = 0;
   logic        m_txp  = 1'b0;
   int          m_frames = 0;

   typedef struct {
      bit          is_meas;
      int          nwords;
      logic [15:0] rx_len;
      logic [15:0] exp_dlen;
      logic [15:0] exp_tlen;
   } vec_t;
   vec_t vecs [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge e_rxc);
      #1;
   endtask

   // RAM write scoreboard
   always @(negedge e_rxc) begin
      if (ram_wren === 1'b1) begin
         if (exp_q.size() == 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                     ram_wraddr, ram_wrdata);
         end else begin
            chk("ram_write", 64'({ram_wraddr, ram_wrdata}), 64'(exp_q.pop_front()));
         end
      end
   end

   task automatic send_meas(input int n, input bit last);
      for (int i = 0; i < n; i++) begin
         int g = 0;
         meas_valid = 1'b1;
         meas_data  = $urandom;
         meas_last  = last && (i == n - 1);
         while (!meas_ready && g < 1000) begin
            tick();
            g++;
         end
         if (g >= 1000) begin
            chk("meas_ready_wait", 64'(meas_ready), 64'(1));
            break;
         end
         exp_q.push_back({m_fill, 8'(m_wcnt), meas_data});
         m_wcnt++;
         if (meas_last || m_wcnt == 256) begin
            m_fill = ~m_fill;
            m_wcnt = 0;
         end
         tick();
      end
      meas_valid = 1'b0;
      meas_last  = 1'b0;
   endtask

   task automatic send_echo(input int n, input logic [15:0] len, input bit expect_wr);
      for (int i = 0; i < n; i++) begin
         rx_wr_valid = 1'b1;
         rx_wr_addr  = 9'(i) | 9'h100;
         rx_wr_data  = $urandom;
         if (expect_wr) exp_q.push_back({m_fill, 8'(i), rx_wr_data});
         tick();
      end
      rx_wr_valid    = 1'b0;
      rx_frame_done  = 1'b1;
      rx_data_length = len;
      tick();
      rx_frame_done  = 1'b0;
      if (expect_wr) m_fill = ~m_fill;
   endtask

   task automatic serve(input logic [15:0] dl, input logic [15:0] tl);
      int g = 0;
      while (!tx_req && g < 200) begin
         tick();
         g++;
      end
      chk("tx_req_rise", 64'(tx_req), 64'(1));
      chk("tx_bank", 64'(tx_bank), 64'(m_txp));
      chk("tx_data_length", 64'(tx_data_length), 64'(dl));
      chk("tx_total_length", 64'(tx_total_length), 64'(tl));
      tx_busy = 1'b1;
      tick();
      chk("tx_req_fall", 64'(tx_req), 64'(0));
      tick();
      chk("tx_len_stable", 64'({tx_data_length, tx_total_length}), 64'({dl, tl}));
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tx_busy = 1'b0;
      m_txp = ~m_txp;
      m_frames++;
      chk("frames_sent", 64'(frames_sent), 64'(m_frames));
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, 64'({meas_ready, ram_wren, ram_wraddr, ram_wrdata, tx_req, tx_bank}), 64'(0));
      chk(name, 64'({tx_data_length, tx_total_length, frames_sent, drop_cnt}), 64'(0));
   endtask

   initial begin
      int g;
      vecs[0] = '{1'b1, 7, 16'd0,  16'd36, 16'd56};
      vecs[1] = '{1'b0, 4, 16'd24, 16'd24, 16'd44};
      vecs[2] = '{1'b1, 1, 16'd0,  16'd12, 16'd32};
      vecs[3] = '{1'b0, 8, 16'd40, 16'd40, 16'd60};
      vecs[4] = '{1'b1, 16, 16'd0, 16'd72, 16'd92};

      reset = 1'b1; rx_wr_valid = 1'b0; rx_wr_addr = 9'd0; rx_wr_data = 32'd0;
      rx_frame_done = 1'b0; rx_data_length = 16'd0; meas_valid = 1'b0;
      meas_data = 32'd0; meas_last = 1'b0; tx_busy = 1'b0; tx_done = 1'b0;
      tick(); tick();
      chk_all_zero("reset_state");
      reset = 1'b0;
      tick();
      chk("idle_meas_ready", 64'(meas_ready), 64'(1));
      rx_wr_valid = 1'b1;
      #1;
      chk("echo_blocks_meas_ready", 64'(meas_ready), 64'(0));
      rx_wr_valid = 1'b0;
      #1;

      // table of single frames, each served before the next
      for (int v = 0; v < 5; v++) begin
         if (vecs[v].is_meas) send_meas(vecs[v].nwords, 1'b1);
         else send_echo(vecs[v].nwords, vecs[v].rx_len, 1'b1);
         serve(vecs[v].exp_dlen, vecs[v].exp_tlen);
      end

      // two frames queued, third blocked until the first tx_done
      send_meas(5, 1'b1);
      send_meas(3, 1'b1);
      meas_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("both_full_meas_ready", 64'(meas_ready), 64'(0));
         tick();
      end
      meas_valid = 1'b0;
      serve(16'd28, 16'd48);
      chk("freed_meas_ready", 64'(meas_ready), 64'(1));
      send_meas(2, 1'b1);
      serve(16'd20, 16'd40);
      serve(16'd16, 16'd36);

      // echo frame during a measurement frame is dropped
      send_meas(3, 1'b0);
      send_echo(4, 16'd24, 1'b0);
      chk("drop_cnt", 64'(drop_cnt), 64'(1));
      send_meas(2, 1'b1);
      serve(16'd28, 16'd48);

      // 300 words without meas_last: forced commit at 256
      send_meas(300, 1'b0);
      serve(16'd1032, 16'd1052);

      // close the partial frame, then reset mid-frame with tx_req high
      send_meas(1, 1'b1);
      g = 0;
      while (!tx_req && g < 20) begin
         tick();
         g++;
      end
      chk("pre_reset_tx_req", 64'({tx_req, tx_data_length}), 64'({1'b1, 16'd188}));
      send_meas(2, 1'b0);
      reset = 1'b1;
      tick();
      chk_all_zero("mid_frame_reset");
      reset = 1'b0;
      m_fill = 1'b0; m_wcnt = 0; m_txp = 1'b0; m_frames = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("no_req_after_reset", 64'({tx_req, ram_wren}), 64'(0));
      end
      send_meas(2, 1'b1);
      chk("commit_latency_n1", 64'(tx_req), 64'(0));
      tick();
      chk("commit_latency_n2", 64'(tx_req), 64'(1));
      serve(16'd16, 16'd36);

      tick(); tick();
      chk("pending_writes", 64'(exp_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
